// File: rtl/sdram_wr_pkg.sv
// sdram_wr_pkg: shared types and helpers for the SDRAM frame writer
package sdram_wr_pkg;
  typedef enum logic [1:0] {IDLE, WAIT_DATA, BURST, FINISH} state_t;
  localparam logic [127:0] BE_ALL_ONES = '1;
  function automatic logic [31:0] min_bc(input logic [31:0] rem, input logic [31:0] burst_len);
    return rem < burst_len ? rem : burst_len;
  endfunction
endpackage

// File: rtl/sdram_wr_fifo.sv
// sdram_wr_fifo: synchronous show-ahead FIFO, head word always visible on dout
module sdram_wr_fifo #(
  parameter int DATA_W     = 64,
  parameter int FIFO_DEPTH = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  logic                          pop,
  input  logic [DATA_W-1:0]             din,
  output logic [DATA_W-1:0]             dout,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0] count_q;
  logic do_push, do_pop;
  assign full    = count_q == (AW+1)'(FIFO_DEPTH);
  assign empty   = count_q == '0;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rp_q];
  assign count   = count_q;
  // pointers and occupancy; a simultaneous push and pop leaves the count unchanged
  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
    end else begin
      wp_q    <= wp_q + AW'(do_push);
      rp_q    <= rp_q + AW'(do_pop);
      count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
  // storage needs no reset: only the pointers decide which words are valid
  always_ff @(posedge clk) if (do_push) mem_q[wp_q] <= din;
endmodule

// File: rtl/sdram_frame_writer.sv
// sdram_frame_writer: Avalon-MM burst write master streaming one frame into DDR3
module sdram_frame_writer
  import sdram_wr_pkg::*;
#(
  parameter int DATA_W     = 64,
  parameter int ADDR_W     = 29,
  parameter int BURST_LEN  = 16,
  parameter int BURST_W    = 5,
  parameter int FIFO_DEPTH = 64,
  parameter int LEN_W      = 24
) (
  input  logic                  clk100,
  input  logic                  reset,
  input  logic [ADDR_W-1:0]     cfg_base_addr,
  input  logic [LEN_W-1:0]      cfg_frame_words,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  input  logic [DATA_W-1:0]     in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [ADDR_W-1:0]     avm_address,
  output logic [BURST_W-1:0]    avm_burstcount,
  output logic [DATA_W-1:0]     avm_writedata,
  output logic [DATA_W/8-1:0]   avm_byteenable,
  output logic                  avm_write,
  input  logic                  avm_waitrequest
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d, avm_addr_q, avm_addr_d;
  logic [LEN_W-1:0] rem_wr_q, rem_wr_d, rem_in_q, rem_in_d;
  logic [BURST_W-1:0] bc_q, bc_d, beat_q, beat_d, bc_next;
  logic wr_q, wr_d;
  logic push, pop, full, last;
  logic [CW-1:0] count;
  assign busy           = state_q != IDLE;
  assign done           = state_q == FINISH;
  assign in_ready       = busy && !full && rem_in_q != '0;
  assign push           = in_valid && in_ready;
  assign pop            = wr_q && !avm_waitrequest;
  assign last           = pop && beat_q == bc_q - BURST_W'(1);
  assign bc_next        = BURST_W'(min_bc(32'(rem_wr_q), 32'(BURST_LEN)));
  assign avm_write      = wr_q;
  assign avm_address    = avm_addr_q;
  assign avm_burstcount = bc_q;
  assign avm_byteenable = BE_ALL_ONES[DATA_W/8-1:0];
  sdram_wr_fifo #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk100),
    .rst(reset),
    .push,
    .pop,
    .din(in_data),
    .dout(avm_writedata),
    .full,
    .empty(),
    .count
  );
  // frame sequencing: a burst is only launched once all its beats are buffered
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    avm_addr_d = avm_addr_q;
    rem_wr_d   = rem_wr_q;
    rem_in_d   = push ? rem_in_q - LEN_W'(1) : rem_in_q;
    bc_d       = bc_q;
    beat_d     = beat_q;
    wr_d       = wr_q;
    case (state_q)
      IDLE: if (start) begin
        addr_d   = cfg_base_addr;
        rem_wr_d = cfg_frame_words;
        rem_in_d = cfg_frame_words;
        state_d  = cfg_frame_words == '0 ? FINISH : WAIT_DATA;
      end
      WAIT_DATA: if (32'(count) >= 32'(bc_next)) begin
        avm_addr_d = addr_q;
        bc_d       = bc_next;
        beat_d     = '0;
        wr_d       = 1'b1;
        state_d    = BURST;
      end
      BURST: if (pop) begin
        beat_d   = beat_q + BURST_W'(1);
        rem_wr_d = rem_wr_q - LEN_W'(1);
        if (last) begin
          wr_d    = 1'b0;
          addr_d  = addr_q + ADDR_W'(bc_q);
          state_d = rem_wr_q == LEN_W'(1) ? FINISH : WAIT_DATA;
        end
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // state and datapath registers
  always_ff @(posedge clk100) begin
    if (reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      avm_addr_q <= '0;
      rem_wr_q   <= '0;
      rem_in_q   <= '0;
      bc_q       <= '0;
      beat_q     <= '0;
      wr_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      avm_addr_q <= avm_addr_d;
      rem_wr_q   <= rem_wr_d;
      rem_in_q   <= rem_in_d;
      bc_q       <= bc_d;
      beat_q     <= beat_d;
      wr_q       <= wr_d;
    end
  end
endmodule

// File: tb/tb_sdram_frame_writer.sv
// tb_sdram_frame_writer: randomized frame writes checked against an arithmetic burst model
module tb_sdram_frame_writer;
  localparam int DW = 64, AW = 29, BL = 16, BW = 5, FD = 64, LW = 24;
  logic clk100 = 0, reset = 1, start = 0, in_valid = 0, avm_waitrequest = 0;
  logic [AW-1:0] cfg_base_addr = '0;
  logic [LW-1:0] cfg_frame_words = '0;
  logic [DW-1:0] in_data = '0;
  logic busy, done, in_ready, avm_write;
  logic [AW-1:0] avm_address;
  logic [BW-1:0] avm_burstcount;
  logic [DW-1:0] avm_writedata;
  logic [DW/8-1:0] avm_byteenable;
  sdram_frame_writer #(.DATA_W(DW), .ADDR_W(AW), .BURST_LEN(BL), .BURST_W(BW), .FIFO_DEPTH(FD), .LEN_W(LW)) dut (
    .clk100(clk100), .reset(reset), .cfg_base_addr(cfg_base_addr), .cfg_frame_words(cfg_frame_words),
    .start(start), .busy(busy), .done(done), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .avm_address(avm_address), .avm_burstcount(avm_burstcount), .avm_writedata(avm_writedata),
    .avm_byteenable(avm_byteenable), .avm_write(avm_write), .avm_waitrequest(avm_waitrequest)
  );
  always #5 clk100 = ~clk100;
  int checks = 0, errors = 0;
  int pv = 100, pw = 0, go_n = 0, lim_n = 0;
  bit go = 0, rst_req = 1, prev_last = 0;
  logic [AW-1:0] go_base = '0, cur_addr = '0;
  logic [31:0] tag = '0;
  int cyc = 0, in_acc = 0, done_cnt = 0, busy_cyc = 0, done_cyc = -1, last_beat_cyc = -1, start_cyc = -1;
  int cur_beats = 0, cur_bc = 0;
  int viol_stable = 0, viol_gap = 0, viol_over = 0;
  logic [DW-1:0] got_data[$];
  logic [AW-1:0] got_addr[$];
  int got_bc[$];
  task automatic step();
    @(negedge clk100);
    reset = rst_req;
    start = go;
    if (go) begin
      cfg_base_addr = go_base;
      cfg_frame_words = LW'(go_n);
      start_cyc = cyc;
    end
    go = 0;
    in_valid = $urandom_range(99) < 32'(pv);
    in_data = {tag, 32'(in_acc)};
    avm_waitrequest = $urandom_range(99) < 32'(pw);
    #1;
    if (in_valid && in_ready) begin
      if (in_acc >= lim_n) viol_over++;
      in_acc++;
    end
    if (prev_last && avm_write) viol_gap++;
    prev_last = 0;
    if (cur_beats > 0 && (!avm_write || avm_address !== cur_addr || int'(avm_burstcount) != cur_bc)) viol_stable++;
    if (avm_write && !avm_waitrequest) begin
      if (cur_beats == 0) begin
        cur_addr = avm_address;
        cur_bc = int'(avm_burstcount);
        got_addr.push_back(cur_addr);
        got_bc.push_back(cur_bc);
      end
      got_data.push_back(avm_writedata);
      cur_beats++;
      last_beat_cyc = cyc;
      if (cur_beats >= cur_bc) begin
        cur_beats = 0;
        prev_last = 1;
      end
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (busy) busy_cyc++;
    if (reset) begin
      cur_beats = 0;
      prev_last = 0;
    end
    cyc++;
  endtask
  task automatic run_frame(input logic [AW-1:0] base, input int n, input int p_v, input int p_w,
                           input int restart_at, input int abort_at);
    int budget;
    bit restarted;
    got_data.delete(); got_addr.delete(); got_bc.delete();
    in_acc = 0; done_cnt = 0; busy_cyc = 0; done_cyc = -1; last_beat_cyc = -1;
    cur_beats = 0; prev_last = 0; viol_stable = 0; viol_gap = 0; viol_over = 0;
    lim_n = n; tag = $urandom; pv = p_v; pw = p_w;
    go_base = base; go_n = n; go = 1;
    budget = 200 + 20 * n;
    restarted = 0;
    while (done_cnt == 0 && budget > 0 && !(abort_at >= 0 && got_data.size() >= abort_at)) begin
      if (!restarted && restart_at >= 0 && got_data.size() >= restart_at) begin
        go = 1; go_base = base ^ 29'h0155_5555; go_n = 8; restarted = 1;
      end
      step();
      budget--;
    end
    if (abort_at < 0) begin
      pv = 100;
      repeat (6) step();
    end
  endtask
  function automatic int burst_errs(input logic [AW-1:0] base, input int n);
    int e, nb, left;
    logic [AW-1:0] a;
    e = 0;
    nb = (n + BL - 1) / BL;
    if (got_addr.size() != nb) e++;
    for (int k = 0; k < nb && k < got_addr.size(); k++) begin
      a = base + AW'(k * BL);
      left = n - k * BL;
      if (got_addr[k] !== a) e++;
      if (got_bc[k] != (left < BL ? left : BL)) e++;
    end
    return e;
  endfunction
  function automatic int data_errs(input int n);
    int e;
    e = got_data.size() != n ? 1 : 0;
    for (int i = 0; i < n && i < got_data.size(); i++) if (got_data[i] !== {tag, 32'(i)}) e++;
    return e;
  endfunction
  task automatic test_reset();
    rst_req = 1;
    repeat (3) step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset.busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset.done got %b want 0", done); end
    checks++; if (avm_write !== 1'b0) begin errors++; $display("FAIL reset.avm_write got %b want 0", avm_write); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset.in_ready got %b want 0", in_ready); end
    checks++; if (avm_address !== '0) begin errors++; $display("FAIL reset.avm_address got %h want 0", avm_address); end
    checks++; if (avm_burstcount !== '0) begin errors++; $display("FAIL reset.avm_burstcount got %0d want 0", avm_burstcount); end
    checks++; if (avm_byteenable !== 8'hFF) begin errors++; $display("FAIL reset.byteenable got %h want ff", avm_byteenable); end
    rst_req = 0;
    step();
  endtask
  task automatic test_two_bursts();
    run_frame(29'h1000, 32, 100, 0, -1, -1);
    checks++; if (burst_errs(29'h1000, 32) !== 0) begin errors++; $display("FAIL two_bursts.bursts got %0d bursts, %0d bad want 0 bad", got_addr.size(), burst_errs(29'h1000, 32)); end
    checks++; if (data_errs(32) !== 0) begin errors++; $display("FAIL two_bursts.data got %0d beats, %0d bad want 0 bad", got_data.size(), data_errs(32)); end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL two_bursts.done_count got %0d want 1", done_cnt); end
    checks++; if (done_cyc !== last_beat_cyc + 1) begin errors++; $display("FAIL two_bursts.done_latency got cycle %0d want %0d", done_cyc, last_beat_cyc + 1); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL two_bursts.busy_after got %b want 0", busy); end
    checks++; if (viol_gap !== 0) begin errors++; $display("FAIL two_bursts.gap got %0d violations want 0", viol_gap); end
  endtask
  task automatic test_partial();
    logic [AW-1:0] b;
    b = AW'($urandom);
    run_frame(b, 20, 100, 0, -1, -1);
    checks++; if (burst_errs(b, 20) !== 0) begin errors++; $display("FAIL partial.bursts got %0d bursts, %0d bad want 0 bad", got_addr.size(), burst_errs(b, 20)); end
    checks++; if (in_acc !== 20) begin errors++; $display("FAIL partial.accepted got %0d want 20", in_acc); end
    checks++; if (viol_over !== 0) begin errors++; $display("FAIL partial.overaccept got %0d extra words want 0", viol_over); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL partial.in_ready_after got %b want 0", in_ready); end
    checks++; if (data_errs(20) !== 0) begin errors++; $display("FAIL partial.data got %0d bad want 0", data_errs(20)); end
  endtask
  task automatic test_random();
    logic [AW-1:0] b;
    int n;
    for (int f = 0; f < 4; f++) begin
      b = f == 0 ? 29'h1FFF_FFF8 : AW'($urandom);
      n = f == 0 ? 24 : int'($urandom_range(100, 1));
      run_frame(b, n, 60, 50, -1, -1);
      checks++; if (burst_errs(b, n) !== 0) begin errors++; $display("FAIL random%0d.bursts n=%0d got %0d bursts, %0d bad want 0 bad", f, n, got_addr.size(), burst_errs(b, n)); end
      checks++; if (data_errs(n) !== 0) begin errors++; $display("FAIL random%0d.data n=%0d got %0d beats, %0d bad want 0 bad", f, n, got_data.size(), data_errs(n)); end
      checks++; if (viol_stable !== 0) begin errors++; $display("FAIL random%0d.burst_stable got %0d violations want 0", f, viol_stable); end
      checks++; if (viol_gap !== 0) begin errors++; $display("FAIL random%0d.gap got %0d violations want 0", f, viol_gap); end
      checks++; if (viol_over !== 0) begin errors++; $display("FAIL random%0d.overaccept got %0d want 0", f, viol_over); end
      checks++; if (done_cnt !== 1) begin errors++; $display("FAIL random%0d.done_count got %0d want 1", f, done_cnt); end
      checks++; if (done_cyc !== last_beat_cyc + 1) begin errors++; $display("FAIL random%0d.done_latency got %0d want %0d", f, done_cyc, last_beat_cyc + 1); end
    end
  endtask
  task automatic test_zero();
    run_frame(29'h0ABC, 0, 100, 0, -1, -1);
    checks++; if (got_data.size() !== 0) begin errors++; $display("FAIL zero.beats got %0d want 0", got_data.size()); end
    checks++; if (busy_cyc !== 1) begin errors++; $display("FAIL zero.busy_cycles got %0d want 1", busy_cyc); end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL zero.done_count got %0d want 1", done_cnt); end
    checks++; if (done_cyc !== start_cyc + 1) begin errors++; $display("FAIL zero.done_latency got %0d want %0d", done_cyc, start_cyc + 1); end
    checks++; if (in_acc !== 0) begin errors++; $display("FAIL zero.accepted got %0d want 0", in_acc); end
  endtask
  task automatic test_reset_mid();
    run_frame(29'h3000, 32, 100, 0, -1, 5);
    rst_req = 1;
    step();
    rst_req = 0;
    step();
    checks++; if (avm_write !== 1'b0) begin errors++; $display("FAIL reset_mid.avm_write got %b want 0", avm_write); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_mid.busy got %b want 0", busy); end
    repeat (20) step();
    checks++; if (done_cnt !== 0) begin errors++; $display("FAIL reset_mid.done got %0d pulses want 0", done_cnt); end
    run_frame(29'h2000, 32, 100, 0, -1, -1);
    checks++; if (burst_errs(29'h2000, 32) !== 0) begin errors++; $display("FAIL reset_mid.rerun_bursts got %0d bad want 0", burst_errs(29'h2000, 32)); end
    checks++; if (data_errs(32) !== 0) begin errors++; $display("FAIL reset_mid.rerun_data got %0d bad want 0", data_errs(32)); end
  endtask
  task automatic test_start_ignored();
    run_frame(29'h0400, 40, 100, 0, 3, -1);
    checks++; if (burst_errs(29'h0400, 40) !== 0) begin errors++; $display("FAIL restart.bursts got %0d bursts, %0d bad want 0 bad", got_addr.size(), burst_errs(29'h0400, 40)); end
    checks++; if (data_errs(40) !== 0) begin errors++; $display("FAIL restart.data got %0d bad want 0", data_errs(40)); end
    checks++; if (in_acc !== 40) begin errors++; $display("FAIL restart.accepted got %0d want 40", in_acc); end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL restart.done_count got %0d want 1", done_cnt); end
  endtask
  initial begin
    test_reset();
    test_two_bursts();
    test_partial();
    test_random();
    test_zero();
    test_reset_mid();
    test_start_ignored();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
